// File: rtl/lap_stopwatch.sv
// Millisecond stopwatch / countdown timer in h:m:s.ms with a small lap-capture FIFO.
// All state advances on the rising clock edge; reset is synchronous and active-high.
module lap_stopwatch #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int HOUR_MAX  = 24,
    parameter int LAP_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        clear,
    input  logic        load,
    input  logic        mode,
    input  logic [17:0] preset_epoch,
    input  logic [9:0]  preset_m,
    input  logic        lap,
    input  logic        lap_ready,
    output logic        lap_valid,
    output logic [17:0] lap_epoch,
    output logic [9:0]  lap_m,
    output logic        lap_drop,
    output logic [17:0] epoch,
    output logic [9:0]  m_epoch,
    output logic        tick,
    output logic        overflow,
    output logic        expired
);

    localparam int              DIV        = CLK_HZ / 1000;
    localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST   = PW'(DIV - 1);
    localparam logic [5:0]      HOUR_LAST  = 6'(HOUR_MAX - 1);
    localparam int              AW         = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(LAP_DEPTH);

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [9:0] ms;
    } hms_t;

    hms_t          cur;
    hms_t          up_next;
    hms_t          dn_next;
    hms_t          pre;
    logic [PW-1:0] prescaler;
    logic          mode_r;
    logic          wrap;
    logic          at_zero;
    logic          count_en;
    logic          step;

    assign epoch   = {cur.hour, cur.min, cur.sec};
    assign m_epoch = cur.ms;

    // A down-count that has expired stays halted until clear/load, or until mode_r flips to up.
    assign count_en = run && !(mode_r && expired);
    assign step     = count_en && (prescaler == PRE_LAST);
    assign at_zero  = (cur == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        up_next = cur;
        wrap    = 1'b0;
        if (cur.ms == 10'd999) begin
            up_next.ms = '0;
            if (cur.sec == 6'd59) begin
                up_next.sec = '0;
                if (cur.min == 6'd59) begin
                    up_next.min = '0;
                    if (cur.hour == HOUR_LAST) begin
                        up_next.hour = '0;
                        wrap         = 1'b1;
                    end else begin
                        up_next.hour = cur.hour + 6'd1;
                    end
                end else begin
                    up_next.min = cur.min + 6'd1;
                end
            end else begin
                up_next.sec = cur.sec + 6'd1;
            end
        end else begin
            up_next.ms = cur.ms + 10'd1;
        end
    end

    // Borrow chain; only used when the current time is non-zero, so hour never underflows.
    always_comb begin
        dn_next = cur;
        if (cur.ms == 10'd0) begin
            dn_next.ms = 10'd999;
            if (cur.sec == 6'd0) begin
                dn_next.sec = 6'd59;
                if (cur.min == 6'd0) begin
                    dn_next.min  = 6'd59;
                    dn_next.hour = cur.hour - 6'd1;
                end else begin
                    dn_next.min = cur.min - 6'd1;
                end
            end else begin
                dn_next.sec = cur.sec - 6'd1;
            end
        end else begin
            dn_next.ms = cur.ms - 10'd1;
        end
    end

    always_comb begin
        pre.hour = (preset_epoch[17:12] > HOUR_LAST) ? HOUR_LAST : preset_epoch[17:12];
        pre.min  = (preset_epoch[11:6]  > 6'd59)     ? 6'd59     : preset_epoch[11:6];
        pre.sec  = (preset_epoch[5:0]   > 6'd59)     ? 6'd59     : preset_epoch[5:0];
        pre.ms   = (preset_m            > 10'd999)   ? 10'd999   : preset_m;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur       <= '0;
            prescaler <= '0;
            mode_r    <= 1'b0;
            tick      <= 1'b0;
            overflow  <= 1'b0;
            expired   <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!run) begin
                mode_r <= mode;
            end
            if (clear) begin
                cur       <= '0;
                prescaler <= '0;
                overflow  <= 1'b0;
                expired   <= 1'b0;
            end else if (load && !run) begin
                cur       <= pre;
                prescaler <= '0;
                overflow  <= 1'b0;
                expired   <= 1'b0;
            end else if (count_en) begin
                if (step) begin
                    prescaler <= '0;
                    if (!mode_r) begin
                        cur  <= up_next;
                        tick <= 1'b1;
                        if (wrap) begin
                            overflow <= 1'b1;
                        end
                    end else if (at_zero) begin
                        expired <= 1'b1;
                    end else begin
                        cur  <= dn_next;
                        tick <= 1'b1;
                        if (dn_next == '0) begin
                            expired <= 1'b1;
                        end
                    end
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
        end
    end

    hms_t          mem [LAP_DEPTH];
    hms_t          head;
    hms_t          head_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [AW:0]   remain;
    logic          pop;
    logic          do_push;
    logic          drop;

    assign lap_valid = (count != '0);
    assign lap_epoch = {head.hour, head.min, head.sec};
    assign lap_m     = head.ms;

    // The head register is preloaded with the next entry so it is stable while the consumer stalls.
    always_comb begin
        pop        = lap_valid && lap_ready;
        do_push    = lap && ((count != FULL_COUNT) || pop);
        drop       = lap && (count == FULL_COUNT) && !pop;
        rd_next    = rd_ptr + AW'(pop);
        remain     = count - (AW + 1)'(pop);
        count_next = remain + (AW + 1)'(do_push);
        head_next  = head;
        if (count_next != '0) begin
            head_next = (remain == '0) ? cur : mem[rd_next];
        end
    end

    // NOTE: the storage array carries no reset; the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= cur;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head     <= '0;
            lap_drop <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(do_push);
            rd_ptr   <= rd_next;
            count    <= count_next;
            head     <= head_next;
            lap_drop <= drop;
        end
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch with DIV = 4, HOUR_MAX = 2, LAP_DEPTH = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lap_stopwatch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        mode = 1'b0;
    logic [17:0] preset_epoch = '0;
    logic [9:0]  preset_m = '0;
    logic        lap = 1'b0;
    logic        lap_ready = 1'b0;
    logic        lap_valid;
    logic [17:0] lap_epoch;
    logic [9:0]  lap_m;
    logic        lap_drop;
    logic [17:0] epoch;
    logic [9:0]  m_epoch;
    logic        tick;
    logic        overflow;
    logic        expired;

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;
    int t0;

    lap_stopwatch #(
        .CLK_HZ   (4000),
        .HOUR_MAX (2),
        .LAP_DEPTH(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .load        (load),
        .mode        (mode),
        .preset_epoch(preset_epoch),
        .preset_m    (preset_m),
        .lap         (lap),
        .lap_ready   (lap_ready),
        .lap_valid   (lap_valid),
        .lap_epoch   (lap_epoch),
        .lap_m       (lap_m),
        .lap_drop    (lap_drop),
        .epoch       (epoch),
        .m_epoch     (m_epoch),
        .tick        (tick),
        .overflow    (overflow),
        .expired     (expired)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    function automatic logic [17:0] ep(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load_preset(input int h, input int m, input int s, input int ms);
        preset_epoch = ep(h, m, s);
        preset_m     = 10'(ms);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic run_for(input int n);
        run = 1'b1;
        cyc(n);
        run = 1'b0;
    endtask

    initial begin
        // 1: reset state, first millisecond, pause holds
        cyc(2);
        check("rst_epoch", 32'(epoch), 32'd0);
        check("rst_m", 32'(m_epoch), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_exp", 32'(expired), 32'd0);
        check("rst_valid", 32'(lap_valid), 32'd0);
        check("rst_drop", 32'(lap_drop), 32'd0);
        reset = 1'b0;
        run = 1'b1;
        cyc(3);
        check("pre_step_m", 32'(m_epoch), 32'd0);
        cyc(1);
        run = 1'b0;
        check("step1_m", 32'(m_epoch), 32'd1);
        check("step1_tick", 32'(tick), 32'd1);
        check("step1_epoch", 32'(epoch), 32'd0);
        cyc(1);
        check("tick_one_cycle", 32'(tick), 32'd0);
        cyc(9);
        check("pause_m", 32'(m_epoch), 32'd1);
        check("pause_epoch", 32'(epoch), 32'd0);

        // 2: up-count carries, preset saturation, overflow wrap
        mode = 1'b0;
        load_preset(0, 59, 59, 999);
        check("load_epoch", 32'(epoch), 32'(ep(0, 59, 59)));
        check("load_m", 32'(m_epoch), 32'd999);
        run_for(4);
        check("carry_epoch", 32'(epoch), 32'(ep(1, 0, 0)));
        check("carry_m", 32'(m_epoch), 32'd0);
        check("carry_tick", 32'(tick), 32'd1);
        check("carry_ovf", 32'(overflow), 32'd0);
        load_preset(5, 63, 60, 1023);
        check("sat_epoch", 32'(epoch), 32'(ep(1, 59, 59)));
        check("sat_m", 32'(m_epoch), 32'd999);
        run_for(4);
        check("wrap_epoch", 32'(epoch), 32'd0);
        check("wrap_m", 32'(m_epoch), 32'd0);
        check("wrap_ovf", 32'(overflow), 32'd1);
        run_for(4);
        check("after_wrap_m", 32'(m_epoch), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // 3: down-count borrow, expiry halts, step at zero
        mode = 1'b1;
        load_preset(0, 0, 1, 1);
        check("load_clr_ovf", 32'(overflow), 32'd0);
        run_for(8);
        check("borrow_epoch", 32'(epoch), 32'd0);
        check("borrow_m", 32'(m_epoch), 32'd999);
        check("borrow_exp", 32'(expired), 32'd0);
        load_preset(0, 0, 0, 1);
        run_for(4);
        check("expire_m", 32'(m_epoch), 32'd0);
        check("expire_flag", 32'(expired), 32'd1);
        t0 = tick_cnt + int'(tick);
        run_for(20);
        check("halt_ticks", 32'(tick_cnt), 32'(t0));
        check("halt_tick", 32'(tick), 32'd0);
        check("halt_m", 32'(m_epoch), 32'd0);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("clear_exp", 32'(expired), 32'd0);
        run_for(4);
        check("zero_step_exp", 32'(expired), 32'd1);
        check("zero_step_tick", 32'(tick), 32'd0);
        check("zero_step_m", 32'(m_epoch), 32'd0);

        // 4: lap FIFO fill, overflow drop, drain in order
        mode = 1'b0;
        lap_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_preset(0, i, i, 100 + i);
            lap = 1'b1;
            cyc(1);
            lap = 1'b0;
            if (i == 0) begin
                check("lap_valid_first", 32'(lap_valid), 32'd1);
                check("lap_head_first", 32'(lap_m), 32'd100);
            end
            if (i == 3) check("lap_nodrop_full", 32'(lap_drop), 32'd0);
            if (i == 4) check("lap_drop_pulse", 32'(lap_drop), 32'd1);
        end
        cyc(1);
        check("lap_drop_clear", 32'(lap_drop), 32'd0);
        check("lap_head_stable", 32'(lap_epoch), 32'(ep(0, 0, 0)));
        lap_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(lap_valid), 32'd1);
            check($sformatf("drain%0d_epoch", k), 32'(lap_epoch), 32'(ep(0, k, k)));
            check($sformatf("drain%0d_m", k), 32'(lap_m), 32'(100 + k));
            cyc(1);
        end
        check("drain_empty", 32'(lap_valid), 32'd0);
        lap_ready = 1'b0;

        // 5: clear beats a same-cycle step; load ignored while running
        load_preset(0, 0, 5, 500);
        run = 1'b1;
        cyc(3);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("clr_step_epoch", 32'(epoch), 32'd0);
        check("clr_step_m", 32'(m_epoch), 32'd0);
        check("clr_step_tick", 32'(tick), 32'd0);
        preset_epoch = ep(0, 30, 30);
        preset_m = 10'd5;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("run_load_epoch", 32'(epoch), 32'd0);
        check("run_load_m", 32'(m_epoch), 32'd0);
        cyc(3);
        check("resume_m", 32'(m_epoch), 32'd1);
        check("resume_tick", 32'(tick), 32'd1);

        // 6: reset mid-count with a non-empty FIFO
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        check("pre_rst_valid", 32'(lap_valid), 32'd1);
        check("pre_rst_lap_m", 32'(lap_m), 32'd1);
        reset = 1'b1;
        cyc(1);
        run = 1'b0;
        check("mid_rst_valid", 32'(lap_valid), 32'd0);
        check("mid_rst_lap_m", 32'(lap_m), 32'd0);
        check("mid_rst_m", 32'(m_epoch), 32'd0);
        check("mid_rst_epoch", 32'(epoch), 32'd0);
        check("mid_rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
